// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   Packs one-hot instruction-class flags and operand fields into a 32-bit
//   RV32I instruction word. Each word leaves through a one-entry output
//   register with a valid/ready handshake. A sequential byte address goes
//   with each word, so a host or boot loader can stream the words straight
//   into instruction memory.
//
//   A request is malformed when its class flags are not exactly one-hot, or
//   when it is a branch/jal with an odd immediate. A malformed request is
//   still accepted, but it is dropped and counted.
//
// Parameters
//   ADDR_W     word-index width; the address index wraps modulo 2**ADDR_W
//   BASE_ADDR  byte address of the first emitted word
//   ERR_W      width of the saturating error counter
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready is combinational)
//   r_type .. lui         instruction-class flags, expected one-hot
//   rd, rs1, rs2          register fields
//   funct3, funct7        function fields
//   imm                   architectural (unscrambled) immediate
//   out_valid / out_ready output handshake
//   out_instr             encoded instruction
//   out_addr              BASE_ADDR + 4*index
//   err                   sticky flag: some request has been dropped
//   err_cnt               number of dropped requests, saturating
// ----------------------------------------------------------------------------
module instr_encoder #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              r_type,
  input  logic              i_type,
  input  logic              store,
  input  logic              load,
  input  logic              branch,
  input  logic              jalr,
  input  logic              jal,
  input  logic              auipc,
  input  logic              lui,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_addr,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  logic              r_full;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_idx;
  logic              r_err;
  logic [ERR_W-1:0]  r_err_cnt;

  logic [8:0]  w_flags;
  logic        w_onehot;
  logic        w_bad;
  logic        w_accept;
  logic        w_pop;
  logic [31:0] w_enc;
  logic [31:0] w_offset;

  assign w_flags  = {r_type, i_type, store, load, branch, jalr, jal, auipc, lui};
  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign w_onehot = (w_flags != 9'd0) && ((w_flags & (w_flags - 9'd1)) == 9'd0);
  // Branch and jal offsets are in half-words, so an odd immediate cannot be encoded.
  assign w_bad    = !w_onehot || ((branch || jal) && imm[0]);

  assign in_ready = !rst && (!r_full || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_pop    = r_full && out_ready;

  // The flag checks below are in priority order. That order does not matter,
  // because the encoding is only stored when exactly one flag is set.
  always_comb begin
    w_enc = 32'd0;
    if (r_type) begin
      w_enc = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
    end else if (i_type) begin
      w_enc = {imm[11:0], rs1, funct3, rd, 7'b0010011};
      // The shift-immediate forms carry funct7 and a 5-bit shift amount in the imm slot.
      if (funct3 == 3'b001 || funct3 == 3'b101) begin
        w_enc[31:20] = {funct7, imm[4:0]};
      end
    end else if (load) begin
      w_enc = {imm[11:0], rs1, funct3, rd, 7'b0000011};
    end else if (jalr) begin
      w_enc = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
    end else if (store) begin
      w_enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
    end else if (branch) begin
      w_enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
    end else if (lui) begin
      w_enc = {imm[31:12], rd, 7'b0110111};
    end else if (auipc) begin
      w_enc = {imm[31:12], rd, 7'b0010111};
    end else if (jal) begin
      w_enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= 1'b0;
      r_instr   <= 32'd0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      // The index advances on every pop. A word accepted in the same cycle
      // therefore lands at the next address.
      if (w_pop) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_accept && !w_bad) begin
        r_full  <= 1'b1;
        r_instr <= w_enc;
      end else if (w_pop) begin
        r_full <= 1'b0;
      end
      if (w_accept && w_bad) begin
        r_err <= 1'b1;
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
    end
  end

  assign w_offset  = 32'(r_idx);
  assign out_valid = r_full;
  assign out_instr = r_instr;
  assign out_addr  = BASE_ADDR + (w_offset << 2);
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
//   Bench for instr_encoder. The DUT is built with a 2-bit index, so address
//   wrap comes up quickly. It is also built with a 3-bit error counter, so
//   saturation comes up quickly.
//
//   The bench keeps a scoreboard queue of expected {instr, addr} pairs.
//   Expected instruction words come from hand-encoded vectors. Addresses come
//   from a word counter kept by the bench.
// ----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int          AW   = 2;
  localparam int          EW   = 3;
  localparam logic [31:0] BASE = 32'h0000_1000;

  localparam logic [8:0] F_R  = 9'h100;
  localparam logic [8:0] F_I  = 9'h080;
  localparam logic [8:0] F_S  = 9'h040;
  localparam logic [8:0] F_L  = 9'h020;
  localparam logic [8:0] F_B  = 9'h010;
  localparam logic [8:0] F_JR = 9'h008;
  localparam logic [8:0] F_J  = 9'h004;
  localparam logic [8:0] F_AU = 9'h002;
  localparam logic [8:0] F_LU = 9'h001;

  typedef struct {
    logic [8:0]  flags;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        good;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [8:0]    cur_flags;
  logic          r_type, i_type, store, load, branch, jalr, jal, auipc, lui;
  logic [4:0]    rd, rs1, rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_addr;
  logic          err;
  logic [EW-1:0] err_cnt;

  logic        cur_good;
  logic [31:0] cur_exp;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   exp_idx = 0;
  int   exp_cnt = 0;
  logic exp_err = 1'b0;

  vec_t tbl[19];

  assign {r_type, i_type, store, load, branch, jalr, jal, auipc, lui} = cur_flags;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r_type(r_type), .i_type(i_type), .store(store), .load(load),
    .branch(branch), .jalr(jalr), .jal(jal), .auipc(auipc), .lui(lui),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .err_cnt(err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [8:0] fl, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] im, input logic good, input logic [31:0] e);
    vec_t v;
    v.flags = fl; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.f3 = f3; v.f7 = f7;
    v.imm = im; v.good = good; v.exp = e;
    return v;
  endfunction

  // Scoreboard monitor, sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_idx = 0;
      exp_cnt = 0;
      exp_err = 1'b0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("in_ready", 32'(in_ready), 32'((sb.size() == 0) || out_ready));
      chk("err", 32'(err), 32'(exp_err));
      chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        $display("word  addr=%h instr=%h (expected %h @ %h)", out_addr, out_instr, e.instr, e.addr);
        chk("out_instr", out_instr, e.instr);
        chk("out_addr", out_addr, e.addr);
      end
      if (in_valid && in_ready) begin
        if (cur_good) begin
          exp_t n;
          n.instr = cur_exp;
          n.addr  = BASE + 32'(4 * exp_idx);
          sb.push_back(n);
          exp_idx = (exp_idx + 1) % (1 << AW);
        end else begin
          $display("drop  request flags=%b imm=%h", cur_flags, imm);
          exp_err = 1'b1;
          if (exp_cnt < (1 << EW) - 1) exp_cnt++;
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    cur_flags = v.flags; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
    cur_good = v.good; cur_exp = v.exp;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready expected accept within 50 clks");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input vec_t v);
    drive(v);
    wait_accept();
  endtask

  initial begin
    tbl[0]  = mk(F_R,  5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'h0000_0000, 1'b1, 32'h002081B3);
    tbl[1]  = mk(F_I,  5'd5,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFF_FFFF, 1'b1, 32'hFFF00293);
    tbl[2]  = mk(F_B,  5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 32'h0000_0008, 1'b1, 32'h00208463);
    tbl[3]  = mk(F_J,  5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_0800, 1'b1, 32'h001000EF);
    tbl[4]  = mk(F_R,  5'd1,  5'd2,  5'd3,  3'd0, 7'h20, 32'h0000_0000, 1'b1, 32'h403100B3);
    tbl[5]  = mk(F_I,  5'd1,  5'd2,  5'd0,  3'd5, 7'h20, 32'hFFFF_FFE3, 1'b1, 32'h40315093);
    tbl[6]  = mk(F_L,  5'd6,  5'd7,  5'd0,  3'd2, 7'h00, 32'hFFFF_FFFC, 1'b1, 32'hFFC3A303);
    tbl[7]  = mk(F_JR, 5'd1,  5'd5,  5'd0,  3'd3, 7'h00, 32'h0000_0010, 1'b1, 32'h010280E7);
    tbl[8]  = mk(F_S,  5'd31, 5'd2,  5'd8,  3'd2, 7'h00, 32'h0000_0024, 1'b1, 32'h02812223);
    tbl[9]  = mk(F_LU, 5'd10, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5678, 1'b1, 32'h12345537);
    tbl[10] = mk(F_AU, 5'd3,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFF_F000, 1'b1, 32'hFFFFF197);
    tbl[11] = mk(F_B,  5'd31, 5'd3,  5'd4,  3'd1, 7'h00, 32'hFFFF_FFFE, 1'b1, 32'hFE419FE3);
    tbl[12] = mk(F_J,  5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFF_FFFC, 1'b1, 32'hFFDFF06F);
    tbl[13] = mk(F_JR, 5'd0,  5'd1,  5'd0,  3'd0, 7'h00, 32'h0000_0001, 1'b1, 32'h00108067);
    tbl[14] = mk(F_R | F_I, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h0000_0000, 1'b0, 32'h0);
    tbl[15] = mk(F_B,  5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 32'h0000_0003, 1'b0, 32'h0);
    tbl[16] = mk(9'h000, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h0000_0000, 1'b0, 32'h0);
    tbl[17] = mk(F_J,  5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_0001, 1'b0, 32'h0);
    tbl[18] = mk(9'h1FF, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h0000_0000, 1'b0, 32'h0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cur_flags = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    cur_good = 1'b0; cur_exp = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values.
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;

    // Back-to-back vectors: every class, boundary immediates and malformed requests.
    for (int i = 0; i < 19; i++) send(tbl[i]);
    repeat (2) @(posedge clk); #1;

    // Back-pressure: the held word stays put and new requests are refused.
    out_ready = 1'b0;
    send(tbl[0]);
    drive(tbl[3]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_instr", out_instr, tbl[0].exp);
      if (sb.size() != 0) chk("stall_out_addr", out_addr, sb[0].addr);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_accept();
    repeat (2) @(posedge clk); #1;

    // The error counter saturates at all-ones.
    for (int k = 0; k < 6; k++) send(tbl[16]);
    @(negedge clk);
    chk("sat_err_cnt", 32'(err_cnt), 32'(7));
    chk("sat_err", 32'(err), 32'd1);
    @(posedge clk); #1;

    // Reset while a word is pending.
    out_ready = 1'b0;
    send(tbl[9]);
    rst = 1'b1;
    drive(tbl[10]);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_addr", out_addr, BASE);
    chk("midrst_out_instr", out_instr, 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // Stream five words. The 2-bit index wraps back to BASE on the fifth.
    for (int i = 0; i < 5; i++) send(tbl[i]);

    // Drain the scoreboard.
    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      chk("drain_left", 32'(sb.size()), 32'd0);
    end
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
